// File: rtl/proto_pkg.sv
// proto_pkg: frame constants, CRC8 definition and FSM state encoding shared
// by the protocol RX and TX stages.
package proto_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'h80;
  localparam logic [7:0] TAIL_BYTE   = 8'h55;
  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam logic [7:0] CRC8_INIT   = 8'h00;
  localparam int         MAX_PAYLOAD = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2,
    TAIL    = 2'd3
  } proto_state_t;

  // One byte of CRC8, MSB first, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_protocol_rx_if.sv
// uart_protocol_rx_if: byte strobe from uart_rx in, decoded frame out.
// master = byte source / frame consumer side, slave = the frame parser.
interface uart_protocol_rx_if;

  logic       uart_rx_done;
  logic [7:0] uart_rx_data;
  logic [7:0] rev_data1;
  logic [7:0] rev_data2;
  logic [7:0] rev_data3;
  logic [7:0] rev_data4;
  logic [7:0] rev_data5;
  logic [7:0] rev_data6;
  logic [7:0] rev_data7;
  logic [7:0] rev_data8;
  logic [7:0] rev_data9;
  logic [7:0] rev_data10;
  logic       recv_done;
  logic       frame_err;
  logic       crc_err;
  logic       busy;

  modport master (
    output uart_rx_done, uart_rx_data,
    input  rev_data1, rev_data2, rev_data3, rev_data4, rev_data5,
           rev_data6, rev_data7, rev_data8, rev_data9, rev_data10,
           recv_done, frame_err, crc_err, busy
  );

  modport slave (
    input  uart_rx_done, uart_rx_data,
    output rev_data1, rev_data2, rev_data3, rev_data4, rev_data5,
           rev_data6, rev_data7, rev_data8, rev_data9, rev_data10,
           recv_done, frame_err, crc_err, busy
  );

endinterface

// File: rtl/crc8.sv
// crc8: running CRC8 register (poly 0x07, init 0x00, MSB first).
module crc8
  import proto_pkg::*;
(
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       crc_en,
  input  logic       crc_clr,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] crc_q;

  // Accumulate one byte per enable; clear has priority so a new frame starts clean.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC8_INIT;
    end else if (crc_clr) begin
      crc_q <= CRC8_INIT;
    end else if (crc_en) begin
      crc_q <= crc8_step(crc_q, data_in);
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/uart_protocol_rx.sv
// uart_protocol_rx: parses header / PAYLOAD_LEN bytes / CRC8 / tail frames from
// the uart_rx byte stream and presents the payload on rev_data1..10.
// Build option PROTO_RX_CRC_CHECK_EN: when defined the CRC byte is checked
// (mismatch -> frame_err + crc_err); when undefined the CRC byte is accepted
// as-is, crc_err stays 0 and no crc8 instance is built.
//
// state   | meaning
// IDLE    | waiting for header byte, strays dropped
// PAYLOAD | collecting payload bytes into the shadow buffer
// CRC     | waiting for the CRC byte
// TAIL    | waiting for the tail byte, frame decided here
module uart_protocol_rx #(
  parameter int         PAYLOAD_LEN = 10,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] HEADER_BYTE = proto_pkg::HEADER_BYTE,
  parameter logic [7:0] TAIL_BYTE   = proto_pkg::TAIL_BYTE
) (
  input logic              clk_50M,
  input logic              rst_n,
  uart_protocol_rx_if.slave bus
);

  import proto_pkg::*;

  localparam int             CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [3:0]     LAST_IDX = 4'(PAYLOAD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  proto_state_t     state_q, state_d;
  logic [3:0]       idx_q;
  logic [7:0]       shadow_q [0:MAX_PAYLOAD-1];
  logic [7:0]       rev_q    [0:MAX_PAYLOAD-1];
  logic [CNT_W-1:0] cnt_q;
  logic             recv_done_q, frame_err_q;
  logic             rx_done;
  logic [7:0]       rx_data;
  logic             timeout, hdr_accept, pay_strobe, commit, frame_bad;
  logic             bad_q;

  assign rx_done = bus.uart_rx_done;
  assign rx_data = bus.uart_rx_data;

  // A byte in the same cycle as the limit wins over the timeout.
  assign timeout = (state_q != IDLE) && !rx_done && (cnt_q == CNT_LAST);

`ifdef PROTO_RX_CRC_CHECK_EN
  logic [7:0] crc_out;
  logic       crc_mismatch;
  logic       crc_err_q;

  crc8 u_crc8 (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .crc_en  (pay_strobe),
    .crc_clr (hdr_accept),
    .data_in (rx_data),
    .crc_out (crc_out)
  );

  assign crc_mismatch = (state_q == CRC) && rx_done && (rx_data != crc_out);

  // Remember a CRC mismatch until the tail decides the frame.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
    end else if (hdr_accept) begin
      bad_q <= 1'b0;
    end else if (crc_mismatch) begin
      bad_q <= 1'b1;
    end
  end

  // crc_err pulses alongside frame_err when the tail finds the bad flag set.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= (state_q == TAIL) && rx_done && bad_q;
    end
  end

  assign bus.crc_err = crc_err_q;
`else
  assign bad_q       = 1'b0;
  assign bus.crc_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: timeout abandons the frame; otherwise advance one step per byte.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (rx_done) begin
      case (state_q)
        IDLE:    if (rx_data == HEADER_BYTE) state_d = PAYLOAD;
        PAYLOAD: if (idx_q == LAST_IDX) state_d = CRC;
        CRC:     state_d = TAIL;
        TAIL:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Per-byte control strobes decoded from state and the incoming byte.
  always_comb begin
    hdr_accept = 1'b0;
    pay_strobe = 1'b0;
    commit     = 1'b0;
    frame_bad  = timeout;
    if (rx_done) begin
      case (state_q)
        IDLE:    hdr_accept = (rx_data == HEADER_BYTE);
        PAYLOAD: pay_strobe = 1'b1;
        TAIL: begin
          commit    = (rx_data == TAIL_BYTE) && !bad_q;
          frame_bad = !((rx_data == TAIL_BYTE) && !bad_q);
        end
        default: ;
      endcase
    end
  end

  // Payload index and shadow buffer; a fresh header or timeout restarts the index.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 4'd0;
      for (int i = 0; i < MAX_PAYLOAD; i++) shadow_q[i] <= 8'h00;
    end else if (hdr_accept || timeout) begin
      idx_q <= 4'd0;
    end else if (pay_strobe) begin
      shadow_q[idx_q] <= rx_data;
      idx_q           <= idx_q + 4'd1;
    end
  end

  // Inter-byte timer: runs only inside a frame, restarted by every byte.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((state_q == IDLE) || rx_done || timeout) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered outputs; rev_data only moves on a valid commit.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      recv_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < MAX_PAYLOAD; i++) rev_q[i] <= 8'h00;
    end else begin
      recv_done_q <= commit;
      frame_err_q <= frame_bad;
      if (commit) begin
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
          if (i < PAYLOAD_LEN) rev_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign bus.recv_done  = recv_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.rev_data1  = rev_q[0];
  assign bus.rev_data2  = rev_q[1];
  assign bus.rev_data3  = rev_q[2];
  assign bus.rev_data4  = rev_q[3];
  assign bus.rev_data5  = rev_q[4];
  assign bus.rev_data6  = rev_q[5];
  assign bus.rev_data7  = rev_q[6];
  assign bus.rev_data8  = rev_q[7];
  assign bus.rev_data9  = rev_q[8];
  assign bus.rev_data10 = rev_q[9];

endmodule
